// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - op-class encodings, default latencies and counter width for the hazard scoreboard
package hazard_pkg;

  typedef enum logic [1:0] {
    OP_ALU  = 2'd0,
    OP_LOAD = 2'd1,
    OP_MUL  = 2'd2,
    OP_DIV  = 2'd3
  } op_class_e;

  localparam int CNT_W        = 4;
  localparam int DEF_LOAD_LAT = 1;
  localparam int DEF_MUL_LAT  = 3;
  localparam int DEF_DIV_LAT  = 8;

endpackage

// File: rtl/hazard_sb_entry.sv
// rtl/hazard_sb_entry.sv - per-register result countdown; busy while the count is nonzero
module hazard_sb_entry
  import hazard_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] value,
  input  logic             freeze,
  output logic             busy
);

  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_next;

  // A fresh allocation overrides the running count (WAW overwrite, not max).
  always_comb begin
    count_next = count;
    if (!freeze) begin
      if (load) begin
        count_next = value;
      end else if (count != '0) begin
        count_next = count - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
      busy  <= 1'b0;
    end else begin
      count <= count_next;
      busy  <= (count_next != '0);
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - register-result scoreboard driving the ID-stage RAW hazard stall
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int NUM_REGS    = 32,
  parameter int LOAD_LAT    = DEF_LOAD_LAT,
  parameter int MUL_LAT     = DEF_MUL_LAT,
  parameter int DIV_LAT     = DEF_DIV_LAT,
  parameter int STALL_CNT_W = 32
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [$clog2(NUM_REGS)-1:0] id_rs1,
  input  logic [$clog2(NUM_REGS)-1:0] id_rs2,
  input  logic                        id_use_rs1,
  input  logic                        id_use_rs2,
  input  logic                        issue_valid,
  input  logic [$clog2(NUM_REGS)-1:0] issue_rd,
  input  logic [1:0]                  issue_class,
  input  logic                        flush,
  input  logic                        mem_stall,
  output logic                        stall,
  output logic [NUM_REGS-1:0]         busy_mask,
  output logic [STALL_CNT_W-1:0]      stall_cycles
);

  localparam int RW = $clog2(NUM_REGS);

  logic [NUM_REGS-1:0] busy;
  logic                alloc;
  logic [CNT_W-1:0]    alloc_value;

  assign busy[0] = 1'b0;

  assign stall = (id_use_rs1 && (id_rs1 != '0) && busy[id_rs1]) ||
                 (id_use_rs2 && (id_rs2 != '0) && busy[id_rs2]);

  always_comb begin
    alloc_value = '0;
    case (op_class_e'(issue_class))
      OP_LOAD: alloc_value = CNT_W'(LOAD_LAT);
      OP_MUL:  alloc_value = CNT_W'(MUL_LAT);
      OP_DIV:  alloc_value = CNT_W'(DIV_LAT);
      default: alloc_value = '0;
    endcase
  end

  // ALU results are forwarded, so they never occupy the scoreboard.
  assign alloc = issue_valid && !stall && !flush && !mem_stall &&
                 (issue_rd != '0) && (op_class_e'(issue_class) != OP_ALU);

  for (genvar i = 1; i < NUM_REGS; i++) begin : g_entry
    hazard_sb_entry u_entry (
      .clk    (clk),
      .rst_n  (rst_n),
      .load   (alloc && (issue_rd == RW'(i))),
      .value  (alloc_value),
      .freeze (mem_stall),
      .busy   (busy[i])
    );
  end

  assign busy_mask = busy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles <= '0;
    end else if (stall && !mem_stall && (stall_cycles != '1)) begin
      stall_cycles <= stall_cycles + STALL_CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb/tb_hazard_scoreboard.sv - directed and randomized checks of hazard_scoreboard against a ready-time model
module tb_hazard_scoreboard;

  localparam int NR = 32;
  localparam int LL = 1;
  localparam int ML = 3;
  localparam int DL = 8;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [4:0]      id_rs1, id_rs2, issue_rd;
  logic            id_use_rs1, id_use_rs2, issue_valid, flush, mem_stall;
  logic [1:0]      issue_class;
  logic            stall, stall_s;
  logic [NR-1:0]   busy_mask, busy_mask_s;
  logic [31:0]     stall_cycles;
  logic [2:0]      stall_cycles_s;

  int tests  = 0;
  int failed = 0;

  // Model: each register is unavailable until cycle avail_at[r].
  int avail_at[NR];
  int now      = 0;
  int m_stalls = 0;

  always #5 clk = ~clk;

  hazard_scoreboard #(.NUM_REGS(NR), .LOAD_LAT(LL), .MUL_LAT(ML), .DIV_LAT(DL), .STALL_CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .issue_valid(issue_valid),
    .issue_rd(issue_rd), .issue_class(issue_class), .flush(flush), .mem_stall(mem_stall),
    .stall(stall), .busy_mask(busy_mask), .stall_cycles(stall_cycles)
  );

  hazard_scoreboard #(.NUM_REGS(NR), .LOAD_LAT(LL), .MUL_LAT(ML), .DIV_LAT(DL), .STALL_CNT_W(3)) dut_sat (
    .clk(clk), .rst_n(rst_n), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .issue_valid(issue_valid),
    .issue_rd(issue_rd), .issue_class(issue_class), .flush(flush), .mem_stall(mem_stall),
    .stall(stall_s), .busy_mask(busy_mask_s), .stall_cycles(stall_cycles_s)
  );

  function automatic int lat_of(input logic [1:0] c);
    case (c)
      2'd1:    return LL;
      2'd2:    return ML;
      2'd3:    return DL;
      default: return 0;
    endcase
  endfunction

  function automatic bit m_busy(input int r);
    return (r != 0) && (now < avail_at[r]);
  endfunction

  function automatic bit m_stall();
    return (id_use_rs1 && m_busy(int'(id_rs1))) || (id_use_rs2 && m_busy(int'(id_rs2)));
  endfunction

  function automatic logic [NR-1:0] m_mask();
    logic [NR-1:0] m;
    m = '0;
    for (int r = 0; r < NR; r++) m[r] = m_busy(r);
    return m;
  endfunction

  function automatic int m_sat();
    return (m_stalls > 7) ? 7 : m_stalls;
  endfunction

  task automatic model_reset();
    for (int r = 0; r < NR; r++) avail_at[r] = 0;
    m_stalls = 0;
  endtask

  task automatic model_edge();
    bit s;
    s = m_stall();
    if (mem_stall) begin
      for (int r = 0; r < NR; r++) if (m_busy(r)) avail_at[r]++;
    end else begin
      if (s) m_stalls++;
      if (issue_valid && !s && !flush && issue_rd != 0 && issue_class != 2'd0)
        avail_at[issue_rd] = now + 1 + lat_of(issue_class);
    end
    now++;
  endtask

  task automatic idle();
    id_rs1 = '0; id_rs2 = '0; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
    issue_valid = 1'b0; issue_rd = '0; issue_class = 2'd0; flush = 1'b0; mem_stall = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic issue(input logic [1:0] cls, input logic [4:0] rd);
    issue_valid = 1'b1; issue_class = cls; issue_rd = rd;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    model_reset();
    @(posedge clk);
    now++;
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    settle();
    tests++; if (stall !== 1'b0) begin failed++; $display("FAIL reset_stall: got %b expected 0", stall); end
    tests++; if (busy_mask !== '0) begin failed++; $display("FAIL reset_busy: got %h expected 0", busy_mask); end
    tests++; if (stall_cycles !== '0) begin failed++; $display("FAIL reset_cnt: got %0d expected 0", stall_cycles); end
    step();
    tests++; if (busy_mask !== '0) begin failed++; $display("FAIL reset_no_alloc: got %h expected 0", busy_mask); end
  endtask

  task automatic test_load_use();
    do_reset();
    issue(2'd1, 5'd5);
    step();
    issue(2'd0, 5'd6); id_rs1 = 5'd5; id_use_rs1 = 1'b1;
    settle();
    tests++; if (stall !== 1'b1) begin failed++; $display("FAIL load_use_stall: got %b expected 1", stall); end
    step();
    settle();
    tests++; if (stall !== 1'b0) begin failed++; $display("FAIL load_use_release: got %b expected 0", stall); end
    tests++; if (stall_cycles !== 32'd1) begin failed++; $display("FAIL load_use_cnt: got %0d expected 1", stall_cycles); end
    step();
  endtask

  task automatic test_div();
    int n;
    do_reset();
    issue(2'd3, 5'd7);
    step();
    issue(2'd0, 5'd8); id_rs2 = 5'd7; id_use_rs2 = 1'b1;
    settle();
    n = 0;
    while (stall && n < 20) begin n++; step(); settle(); end
    tests++; if (n != 8) begin failed++; $display("FAIL div_stall_len: got %0d expected 8", n); end
    do_reset();
    issue(2'd3, 5'd7);
    step();
    issue(2'd0, 5'd8); id_rs2 = 5'd7; id_use_rs2 = 1'b0; id_rs1 = 5'd7; id_use_rs1 = 1'b0;
    settle();
    tests++; if (stall !== 1'b0) begin failed++; $display("FAIL div_unused_rs2: got %b expected 0", stall); end
    tests++; if (busy_mask[7] !== 1'b1) begin failed++; $display("FAIL div_busy7: got %b expected 1", busy_mask[7]); end
    step();
  endtask

  task automatic test_waw();
    do_reset();
    issue(2'd2, 5'd3);
    step();
    issue(2'd1, 5'd3);
    step();
    idle();
    settle();
    tests++; if (busy_mask[3] !== 1'b1) begin failed++; $display("FAIL waw_busy: got %b expected 1", busy_mask[3]); end
    step();
    tests++; if (busy_mask[3] !== 1'b0) begin failed++; $display("FAIL waw_reload: got %b expected 0", busy_mask[3]); end
  endtask

  task automatic test_flush_x0();
    do_reset();
    issue(2'd1, 5'd4); flush = 1'b1;
    step();
    idle();
    settle();
    tests++; if (busy_mask !== '0) begin failed++; $display("FAIL flush_alloc: got %h expected 0", busy_mask); end
    issue(2'd3, 5'd0);
    step();
    idle(); id_use_rs1 = 1'b1; id_use_rs2 = 1'b1;
    settle();
    tests++; if (busy_mask !== '0) begin failed++; $display("FAIL x0_alloc: got %h expected 0", busy_mask); end
    tests++; if (stall !== 1'b0) begin failed++; $display("FAIL x0_stall: got %b expected 0", stall); end
    idle();
  endtask

  task automatic test_mem_stall();
    int n;
    do_reset();
    issue(2'd3, 5'd9);
    step();
    issue(2'd0, 5'd10); id_rs1 = 5'd9; id_use_rs1 = 1'b1;
    n = 0;
    for (int k = 0; k < 30; k++) begin
      mem_stall = (k >= 2 && k < 5);
      settle();
      if (!busy_mask[9]) break;
      n++;
      step();
    end
    tests++; if (n != 11) begin failed++; $display("FAIL memstall_busy_len: got %0d expected 11", n); end
    tests++; if (stall_cycles !== 32'd8) begin failed++; $display("FAIL memstall_cnt: got %0d expected 8", stall_cycles); end
    idle();
  endtask

  task automatic test_async_reset_and_sat();
    do_reset();
    issue(2'd3, 5'd7);
    step();
    issue(2'd0, 5'd8); id_rs1 = 5'd7; id_use_rs1 = 1'b1;
    for (int k = 0; k < 5; k++) step();
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    tests++; if (busy_mask !== '0) begin failed++; $display("FAIL async_busy: got %h expected 0", busy_mask); end
    tests++; if (stall !== 1'b0) begin failed++; $display("FAIL async_stall: got %b expected 0", stall); end
    tests++; if (stall_cycles !== '0) begin failed++; $display("FAIL async_cnt: got %0d expected 0", stall_cycles); end
    do_reset();
    issue(2'd3, 5'd7);
    step();
    issue(2'd0, 5'd8); id_rs1 = 5'd7; id_use_rs1 = 1'b1;
    for (int k = 0; k < 8; k++) step();
    settle();
    tests++; if (stall_cycles_s !== 3'd7) begin failed++; $display("FAIL sat_hold: got %0d expected 7", stall_cycles_s); end
    tests++; if (stall_cycles !== 32'd8) begin failed++; $display("FAIL sat_wide: got %0d expected 8", stall_cycles); end
    idle();
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      id_rs1      = 5'($urandom_range(0, 7));
      id_rs2      = 5'($urandom_range(0, 7));
      id_use_rs1  = 1'($urandom_range(0, 1));
      id_use_rs2  = 1'($urandom_range(0, 1));
      issue_valid = ($urandom_range(0, 3) != 0);
      issue_rd    = 5'($urandom_range(0, 7));
      issue_class = 2'($urandom_range(0, 3));
      flush       = ($urandom_range(0, 7) == 0);
      mem_stall   = ($urandom_range(0, 5) == 0);
      settle();
      tests++; if (stall !== m_stall()) begin failed++; $display("FAIL rnd_stall c=%0d: got %b expected %b", c, stall, m_stall()); end
      tests++; if (busy_mask !== m_mask()) begin failed++; $display("FAIL rnd_busy c=%0d: got %h expected %h", c, busy_mask, m_mask()); end
      tests++; if (stall_cycles !== 32'(m_stalls)) begin failed++; $display("FAIL rnd_cnt c=%0d: got %0d expected %0d", c, stall_cycles, m_stalls); end
      tests++; if (stall_cycles_s !== 3'(m_sat())) begin failed++; $display("FAIL rnd_sat c=%0d: got %0d expected %0d", c, stall_cycles_s, m_sat()); end
      step();
    end
    idle();
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    model_reset();
    test_reset();
    test_load_use();
    test_div();
    test_waw();
    test_flush_x0();
    test_mem_stall();
    test_async_reset_and_sat();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
